// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, controller state encoding and
// the opcode legality helper used by the sharing controller.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational 32-bit ALU shared by all requesters; undefined opcodes
// return zero.
module alu_share_ctrl_alu
  import alu_pkg::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND: result = in1 & in2;
      ALU_OR:  result = in1 | in2;
      ALU_ADD: result = in1 + in2;
      ALU_SUB: result = in1 - in2;
      // Unsigned compare.
      ALU_SLT: result = {31'd0, (in1 < in2)};
      ALU_NOR: result = ~(in1 | in2);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing controller for the single ALU: grants one requester,
// runs the ALU for one cycle and returns the result on a valid/ready channel.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  input  logic [NUM_REQ*4-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_zero,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_illegal,
  output logic                      busy
);

  alu_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_illegal_q, rsp_illegal_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [DATA_W-1:0] sel_in1, sel_in2;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] alu_result;

  // Search upward from the pointer, wrapping, for the first valid requester.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_w       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = ID_W'(idx);
      if (!grant_found && req_valid[idx_w]) begin
        grant_found = 1'b1;
        grant_id    = idx_w;
      end
    end
  end

  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    sel_op  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_in1 = req_in1[i*DATA_W +: DATA_W];
        sel_in2 = req_in2[i*DATA_W +: DATA_W];
        sel_op  = req_op[i*4 +: 4];
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && grant_found && rst_n) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  alu_share_ctrl_alu u_alu (
    .in1    (in1_q),
    .in2    (in2_q),
    .op     (op_q),
    .result (alu_result)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    op_d          = op_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          in1_d   = sel_in1;
          in2_d   = sel_in2;
          op_d    = sel_op;
          id_d    = grant_id;
          ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d    = alu_result;
        rsp_zero_d    = (alu_result == '0);
        rsp_illegal_d = !op_is_legal(op_q);
        state_d       = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      in1_q         <= '0;
      in2_q         <= '0;
      op_q          <= '0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      op_q          <= op_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_id      = id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl with two requesters; every scenario
// task drives its vectors and compares against hand-computed values.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_in1 = '0;
  logic [NUM_REQ*DATA_W-1:0] req_in2 = '0;
  logic [NUM_REQ*4-1:0]      req_op = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_zero;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_illegal;
  logic                      busy;

  int checks = 0;
  int failures = 0;

  alu_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_zero    (rsp_zero),
    .rsp_id      (rsp_id),
    .rsp_illegal (rsp_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    req_in1[r*32 +: 32] = a;
    req_in2[r*32 +: 32] = b;
    req_op[r*4 +: 4]    = op;
  endtask

  // Issues one request, waits for its response and returns what was seen.
  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, output logic [31:0] d, output logic z,
                        output logic [ID_W-1:0] id, output logic ill, output int lat);
    int n;
    @(negedge clk);
    set_req(r, a, b, op);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    rsp_ready    = 1'b1;
    #1;
    n = 0;
    while (req_ready[r] !== 1'b1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 10) begin
      checks++;
      failures++;
      $display("[TB] FAIL grant_timeout req=%0d got req_ready=%b expected accept", r, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid !== 1'b1 && lat < 10);
    d   = rsp_data;
    z   = rsp_zero;
    id  = rsp_id;
    ill = rsp_illegal;
  endtask

  task automatic test_reset();
    #2;
    req_valid = 2'b11;
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    set_req(1, 32'd2, 32'd2, ALU_ADD);
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL reset_req_ready got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (rsp_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_rsp_data got %h expected 0", rsp_data); end
    checks++; if ({rsp_zero, rsp_illegal, rsp_id} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got %b expected 000", {rsp_zero, rsp_illegal, rsp_id}); end
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 2'b00 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_hold got ready=%b busy=%b expected 00/0", req_ready, busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL reset_ptr_grant got %b expected 01", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single_add();
    logic [31:0] d; logic z; logic [ID_W-1:0] id; logic ill; int lat;
    run_op(0, 32'd5, 32'd7, ALU_ADD, d, z, id, ill, lat);
    checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL add_latency got %0d expected 2", lat); end
    checks++; if (d !== 32'd12) begin failures++; $display("[TB] FAIL add_data got %h expected 0000000c", d); end
    checks++; if ({z, id, ill} !== 3'b000) begin failures++; $display("[TB] FAIL add_flags got zero/id/ill=%b expected 000", {z, id, ill}); end
  endtask

  task automatic test_sub_zero();
    logic [31:0] d; logic z; logic [ID_W-1:0] id; logic ill; int lat;
    run_op(1, 32'h1234, 32'h1234, ALU_SUB, d, z, id, ill, lat);
    checks++; if (d !== 32'd0) begin failures++; $display("[TB] FAIL sub_data got %h expected 0", d); end
    checks++; if ({z, id, ill} !== 3'b110) begin failures++; $display("[TB] FAIL sub_flags got zero/id/ill=%b expected 110", {z, id, ill}); end
  endtask

  task automatic test_fairness();
    int ngrant, nresp, c;
    logic [1:0] exp_ready;
    logic [31:0] exp_data;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 32'd1, 32'd2, ALU_ADD);
    set_req(1, 32'd10, 32'd3, ALU_SUB);
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    ngrant = 0;
    nresp  = 0;
    c      = 0;
    while (nresp < 4 && c < 40) begin
      #1;
      if (req_ready !== 2'b00) begin
        exp_ready = (ngrant % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (req_ready !== exp_ready) begin failures++; $display("[TB] FAIL fair_grant%0d got %b expected %b", ngrant, req_ready, exp_ready); end
        ngrant++;
      end
      if (rsp_valid === 1'b1) begin
        exp_data = (nresp % 2 == 0) ? 32'd3 : 32'd7;
        checks++; if (rsp_id !== ID_W'(nresp % 2) || rsp_data !== exp_data) begin
          failures++;
          $display("[TB] FAIL fair_rsp%0d got id=%0d data=%h expected id=%0d data=%h", nresp, rsp_id, rsp_data, nresp % 2, exp_data);
        end
        nresp++;
        if (nresp == 4) req_valid = '0;
      end
      @(negedge clk);
      c++;
    end
    checks++; if (nresp !== 4) begin failures++; $display("[TB] FAIL fair_timeout got %0d responses expected 4", nresp); end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int n;
    logic held_ok;
    @(negedge clk);
    set_req(0, 32'hFF00FF00, 32'h0FF00FF0, ALU_AND);
    set_req(1, 32'h1, 32'h2, ALU_OR);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 10) begin failures++; $display("[TB] FAIL bp_grant got ready=%b expected 01", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0F000F00) begin failures++; $display("[TB] FAIL bp_first got valid=%b data=%h expected 1/0f000f00", rsp_valid, rsp_data); end
    held_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0F000F00 || req_ready !== 2'b00) held_ok = 1'b0;
    end
    checks++; if (held_ok !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold got valid=%b data=%h ready=%b expected 1/0f000f00/00", rsp_valid, rsp_data, req_ready); end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin failures++; $display("[TB] FAIL bp_regrant got valid=%b ready=%b expected 0/10", rsp_valid, req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h3 || rsp_id !== 1'b1) begin failures++; $display("[TB] FAIL bp_second got valid=%b data=%h id=%0d expected 1/00000003/1", rsp_valid, rsp_data, rsp_id); end
  endtask

  task automatic test_illegal_wrap();
    logic [31:0] d; logic z; logic [ID_W-1:0] id; logic ill; int lat;
    run_op(0, 32'hDEAD, 32'hBEEF, 4'b1111, d, z, id, ill, lat);
    checks++; if (d !== 32'd0) begin failures++; $display("[TB] FAIL illegal_data got %h expected 0", d); end
    checks++; if ({z, ill} !== 2'b11) begin failures++; $display("[TB] FAIL illegal_flags got zero/ill=%b expected 11", {z, ill}); end
    run_op(1, 32'hFFFFFFFF, 32'h1, ALU_ADD, d, z, id, ill, lat);
    checks++; if (d !== 32'd0) begin failures++; $display("[TB] FAIL wrap_data got %h expected 0", d); end
    checks++; if ({z, id, ill} !== 3'b110) begin failures++; $display("[TB] FAIL wrap_flags got zero/id/ill=%b expected 110", {z, id, ill}); end
  endtask

  task automatic test_nor_slt();
    logic [31:0] d; logic z; logic [ID_W-1:0] id; logic ill; int lat;
    run_op(0, 32'h0F0F0000, 32'h00000F0F, ALU_NOR, d, z, id, ill, lat);
    checks++; if (d !== 32'hF0F0F0F0) begin failures++; $display("[TB] FAIL nor_data got %h expected f0f0f0f0", d); end
    checks++; if ({z, ill} !== 2'b00) begin failures++; $display("[TB] FAIL nor_flags got zero/ill=%b expected 00", {z, ill}); end
    run_op(1, 32'hFFFFFFFF, 32'h1, ALU_SLT, d, z, id, ill, lat);
    checks++; if (d !== 32'd0 || z !== 1'b1) begin failures++; $display("[TB] FAIL slt_big got data=%h zero=%b expected 0/1", d, z); end
    run_op(1, 32'h1, 32'hFFFFFFFF, ALU_SLT, d, z, id, ill, lat);
    checks++; if (d !== 32'd1 || z !== 1'b0) begin failures++; $display("[TB] FAIL slt_small got data=%h zero=%b expected 1/0", d, z); end
    run_op(0, 32'hA0, 32'h05, ALU_OR, d, z, id, ill, lat);
    checks++; if (d !== 32'hA5 || ill !== 1'b0) begin failures++; $display("[TB] FAIL or_data got data=%h ill=%b expected a5/0", d, ill); end
  endtask

  task automatic test_reset_exec();
    logic quiet;
    @(negedge clk);
    set_req(0, 32'hFFFF, 32'hFFFF, ALU_AND);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL rx_grant got %b expected 01", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rx_exec got busy=%b valid=%b expected 1/0", busy, rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, rsp_valid, rsp_zero, rsp_illegal, rsp_id} !== 5'b00000 || rsp_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rx_clear got flags=%b data=%h expected 00000/0", {busy, rsp_valid, rsp_zero, rsp_illegal, rsp_id}, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin failures++; $display("[TB] FAIL rx_no_response got valid=%b busy=%b expected 0/0", rsp_valid, busy); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL rx_ptr_zero got %b expected 01", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_sub_zero();
    test_fairness();
    test_backpressure();
    test_illegal_wrap();
    test_nor_slt();
    test_reset_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
